ram4x64_fifo_ctrl: RTL and testbench

RAM4X64_FIFO_CTRL -- requirements
Module: ram4x64_fifo_ctrl

---
 rtl/router_mem_pkg.sv | 23 ++
 rtl/mem_rd_obuf.sv | 39 +++
 rtl/ram4x64_fifo_ctrl.sv | 84 ++++++++
 tb/tb_ram4x64_fifo_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_mem_pkg.sv
// rtl/router_mem_pkg.sv - shared sizing, types and helpers for the RAM-backed FIFO controller
package router_mem_pkg;

  localparam int RAM_DEPTH  = 4;
  localparam int RAM_AW     = 2;
  localparam int DATA_W     = 64;
  localparam int RD_LAT     = 2;
  localparam int OBUF_DEPTH = RD_LAT + 1;
  localparam int OBUF_CW    = $clog2(OBUF_DEPTH + 1);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [RAM_AW-1:0] addr_t;
  typedef logic [2:0]        cnt_t;

  // Reads in flight plus words parked in obuf may never exceed obuf capacity.
  localparam cnt_t CREDIT_LIMIT = cnt_t'(RD_LAT + 1);
  localparam cnt_t RAM_FULL     = cnt_t'(RAM_DEPTH);

  function automatic addr_t ptr_inc(input addr_t p);
    return p + addr_t'(1);
  endfunction

endpackage

// File: rtl/mem_rd_obuf.sv
// rtl/mem_rd_obuf.sv - shift-style output buffer; head entry is a register driving pop_data
module mem_rd_obuf
  import router_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [DATA_W-1:0]  push_data,
  input  logic               pop,
  output logic [DATA_W-1:0]  pop_data,
  output logic               full,
  output logic               empty,
  output logic [OBUF_CW-1:0] count
);

  logic [DATA_W-1:0]  data_q [OBUF_DEPTH];
  logic [OBUF_CW-1:0] wr_idx;

  // A simultaneous pop shifts everything down, so the new word lands one slot lower.
  assign wr_idx = count - OBUF_CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) data_q[i] <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < OBUF_DEPTH - 1; i++) data_q[i] <= data_q[i+1];
      end
      if (push) data_q[wr_idx] <= push_data;
      count <= count + OBUF_CW'(push) - OBUF_CW'(pop);
    end
  end

  assign pop_data = data_q[0];
  assign full     = (count == OBUF_CW'(OBUF_DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/ram4x64_fifo_ctrl.sv
// rtl/ram4x64_fifo_ctrl.sv - FIFO controller over an external 4x64 RAM with 2-cycle read latency
module ram4x64_fifo_ctrl
  import router_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              mem_wr_en,
  output logic [RAM_AW-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd_en,
  output logic [RAM_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [2:0]        occupancy
);

  addr_t              wptr, rptr;
  cnt_t               ram_count, ram_vis, inflight;
  logic [RD_LAT-1:0]  tag;
  logic [OBUF_CW-1:0] obuf_count;
  logic               obuf_full, obuf_empty;
  logic               push, pop, rd_issue, capture;

  // ram_count is registered, so a word written this cycle only becomes visible after the edge.
  assign ram_vis  = ram_count;

  assign in_ready = !rst && (ram_count < RAM_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign capture  = tag[RD_LAT-1];
  assign rd_issue = !rst && (ram_vis != '0) &&
                    ((cnt_t'(obuf_count) + inflight) < (CREDIT_LIMIT + cnt_t'(pop)));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + cnt_t'(tag[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      ram_count <= '0;
      tag       <= '0;
    end else begin
      if (push)     wptr <= ptr_inc(wptr);
      if (rd_issue) rptr <= ptr_inc(rptr);
      case ({push, rd_issue})
        2'b10:   ram_count <= ram_count + cnt_t'(1);
        2'b01:   ram_count <= ram_count - cnt_t'(1);
        default: ram_count <= ram_count;
      endcase
      tag <= {tag[RD_LAT-2:0], rd_issue};
    end
  end

  mem_rd_obuf u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (mem_rd_data),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (obuf_full),
    .empty     (obuf_empty),
    .count     (obuf_count)
  );

  assign out_valid   = !obuf_empty;
  assign mem_wr_en   = push;
  assign mem_wr_addr = wptr;
  assign mem_wr_data = in_data;
  assign mem_rd_en   = rd_issue;
  assign mem_rd_addr = rptr;
  assign occupancy   = ram_count + inflight + cnt_t'(obuf_count);

  a_no_overrun: assert property (@(posedge clk) disable iff (rst) !(capture && obuf_full && !pop));

endmodule

// File: tb/tb_ram4x64_fifo_ctrl.sv
// tb/tb_ram4x64_fifo_ctrl.sv - scoreboard bench for ram4x64_fifo_ctrl with a behavioural RAM
module tb_ram4x64_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic        mem_wr_en, mem_rd_en;
  logic [1:0]  mem_wr_addr, mem_rd_addr;
  logic [63:0] mem_wr_data, mem_rd_data;
  logic [2:0]  occupancy;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  int          occ_model = 0;

  logic [63:0] ram [4];
  logic [63:0] rd_q;

  always #5 clk = ~clk;

  ram4x64_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .occupancy(occupancy)
  );

  // External RAM: data appears two edges after the read request is sampled; never reset.
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) rd_q <= ram[mem_rd_addr];
    mem_rd_data <= rd_q;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: model is the ordered list of accepted words plus a pushes-minus-pops counter.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
      chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_addrs", 64'({mem_wr_addr, mem_rd_addr}), 64'd0);
      exp_q.delete();
      occ_model = 0;
    end else begin
      chk("occupancy", 64'(occupancy), 64'(occ_model));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", out_data, 64'hxxxx_xxxx_xxxx_xxxx);
        end else begin
          chk("pop_data", out_data, exp_q.pop_front());
        end
        occ_model--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        occ_model++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'd1);
    cyc();
  endtask

  task automatic single_push(input logic [63:0] d);
    in_valid = 1'b1;
    in_data = d;
    out_ready = 1'b1;
    @(negedge clk);
    chk("sp_wr_en", 64'(mem_wr_en), 64'd1);
    chk("sp_wr_addr", 64'(mem_wr_addr), 64'd0);
    chk("sp_wr_data", mem_wr_data, d);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sp_rd_en", 64'(mem_rd_en), 64'd1);
    chk("sp_rd_addr", 64'(mem_rd_addr), 64'd0);
    cyc();
    @(negedge clk);
    chk("sp_early_c2", 64'(out_valid), 64'd0);
    cyc();
    @(negedge clk);
    chk("sp_early_c3", 64'(out_valid), 64'd0);
    cyc();
    @(negedge clk);
    chk("sp_out_valid", 64'(out_valid), 64'd1);
    chk("sp_out_data", out_data, d);
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc, nxt, gaps, nw, nr, stale;
    logic [1:0] wr_seq [16];
    logic [1:0] rd_seq [16];
    logic seen;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    do_reset();
    single_push(64'hDEAD_BEEF_0000_0001);

    // Fill with the consumer stalled: 3 words in obuf, 4 in RAM.
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    nxt = 0;
    for (int i = 0; i < 12; i++) begin
      in_data = 64'(nxt);
      @(negedge clk);
      if (in_ready) begin
        acc++;
        nxt++;
      end
      cyc();
    end
    chk("fill_accepts", 64'(acc), 64'd7);
    @(negedge clk);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_occupancy", 64'(occupancy), 64'd7);
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (15) cyc();
    chk("fill_drained", 64'(exp_q.size()), 64'd0);

    // Streaming: one word per cycle once the 3-cycle fill has passed.
    gaps = 0;
    for (int i = 0; i < 110; i++) begin
      in_valid = (i < 100);
      in_data = 64'h5000_0000 + 64'(i);
      @(negedge clk);
      if (out_valid !== ((i >= 4) && (i < 104))) gaps++;
      cyc();
    end
    chk("stream_gaps", 64'(gaps), 64'd0);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);

    // Wrap-around of both pointers.
    do_reset();
    out_ready = 1'b1;
    nw = 0;
    nr = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i < 10);
      in_data = 64'hA000 + 64'(i);
      @(negedge clk);
      if (mem_wr_en && nw < 16) begin wr_seq[nw] = mem_wr_addr; nw++; end
      if (mem_rd_en && nr < 16) begin rd_seq[nr] = mem_rd_addr; nr++; end
      cyc();
    end
    chk("wrap_nw", 64'(nw), 64'd10);
    chk("wrap_nr", 64'(nr), 64'd10);
    for (int i = 0; i < 10 && i < nw && i < nr; i++) begin
      chk("wrap_wr_addr", 64'(wr_seq[i]), 64'(i % 4));
      chk("wrap_rd_addr", 64'(rd_seq[i]), 64'(i % 4));
    end

    // Random traffic on both sides.
    for (int i = 0; i < 10000; i++) begin
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      in_data = {$urandom(), $urandom()};
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) cyc();
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("rand_occ_zero", 64'(occupancy), 64'd0);
    cyc();

    // Reset one cycle after a read issue; the returning RAM data must be dropped.
    do_reset();
    in_valid = 1'b1;
    in_data = 64'h0BAD_0BAD_0BAD_0BAD;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      if (mem_rd_en) seen = 1'b1;
      cyc();
    end
    chk("mid_rd_seen", 64'(seen), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_occupancy", 64'(occupancy), 64'd0);
    cyc();
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
      cyc();
    end
    chk("mid_no_stale", 64'(stale), 64'd0);
    single_push(64'hC0FF_EE00_0000_0042);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
